// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and field positions for the UART receive path
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int RX_ENTRY_W = 10;
  localparam int RX_PERR_BIT = 8;
  localparam int RX_SERR_BIT = 9;
  typedef logic [RX_ENTRY_W-1:0] rx_entry_t;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x W register array, synchronous write, asynchronous read
module uart_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int W = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers received bytes with error flags behind a registered valid/ready head
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter bit DROP_ERRORS = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [UART_DATA_W-1:0]   rx_data,
  input  logic                     rx_valid,
  input  logic                     parity_error,
  input  logic                     stop_error,
  output logic [UART_DATA_W-1:0]   m_data,
  output logic                     m_perr,
  output logic                     m_serr,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               err_count,
  input  logic                     flush,
  input  logic                     clear_stats
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  rx_entry_t wdata, rdata, head, head_nxt;
  logic err, drop, pop, push, ovf_evt;
  assign wdata = {stop_error, parity_error, rx_data};
  assign err = rx_valid && (parity_error || stop_error);
  assign drop = DROP_ERRORS && err;
  assign pop = m_valid && m_ready && !flush;
  assign push = rx_valid && !flush && !drop && (!full || pop);
  assign ovf_evt = rx_valid && !flush && !drop && full && !pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign m_valid = !empty;
  assign m_data = head[UART_DATA_W-1:0];
  assign m_perr = head[RX_PERR_BIT];
  assign m_serr = head[RX_SERR_BIT];
  uart_fifo_ram #(.DEPTH(DEPTH), .W(RX_ENTRY_W)) u_ram (
    .clk(clk), .we(push), .waddr(wr_ptr), .wdata(wdata),
    .raddr(rd_ptr + AW'(1)), .rdata(rdata)
  );
  // Prefetch: after a pop the head comes from the slot behind rd_ptr, or straight
  // from the incoming byte when that slot is being written this very cycle.
  always_comb begin
    head_nxt = head;
    if (!flush && pop) head_nxt = (count == CW'(1)) ? (push ? wdata : head) : rdata;
    else if (!flush && push && empty) head_nxt = wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      head <= '0;
      overflow <= 1'b0;
      err_count <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      head <= head_nxt;
      overflow <= ovf_evt || (overflow && !clear_stats);
      err_count <= clear_stats ? 8'(err) : err_count + 8'(err && err_count != 8'hFF);
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of `uart_top`. Captures each `rx_valid` byte together with its parity and stop error flags into a synchronous FIFO. Presents the bytes to the consumer (CPU bus bridge or command parser) over a valid/ready handshake. Also keeps sticky overflow status and a saturating line-error counter, so no byte is lost silently between the UART and a slow consumer.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, minimum 2.
- `DROP_ERRORS`, 0, 1 = bytes with parity or stop error are counted but not stored.
- `clk` in 1: single clock, same clock as `uart_top`.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte from `uart_top`.
- `rx_valid` in 1: one-cycle pulse per received byte.
- `parity_error` in 1: qualifies `rx_data`; sampled with `rx_valid`.
- `stop_error` in 1: qualifies `rx_data`; sampled with `rx_valid`.
- `m_data` out 8: head byte.
- `m_perr` out 1: head parity flag.
- `m_serr` out 1: head stop flag.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts head.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `overflow` out 1: sticky; a byte was discarded because the FIFO was full.
- `err_count` out 8: saturating count of errored bytes received.
- `flush` in 1: discard all stored entries.
- `clear_stats` in 1: clear `overflow` and `err_count`.

## Operation
- Entry width is 10 bits: {serr, perr, data[7:0]}.
- **Push:** `rx_valid` high, `flush` low, not dropped, and either not full or a pop occurs in the same cycle.
  - Writes the entry at `wr_ptr`.
  - `wr_ptr` increments, wrapping modulo DEPTH.
- **Drop on error:** with `DROP_ERRORS`=1, an entry with perr or serr set is not pushed and does not set `overflow`.
- **Overflow:** `rx_valid` while full with no same-cycle pop discards the byte and sets `overflow`. Neither pointer changes.
- **Pop:** `m_valid && m_ready`. `rd_ptr` increments with wrap. `m_ready` while empty is ignored.
- **Push and pop together:** `count` is unchanged. This is legal when full (the slot freed by the pop is reused) and when count==1.
- **Push while empty:** no fall-through.
- **Error counter:** `err_count` increments on every `rx_valid` with perr|serr, independent of `DROP_ERRORS`, full, or flush. It saturates at 255.
- **Flush:** zeroes both pointers and `count`. A push in the same cycle is discarded. A pop in the same cycle is ignored. Flush does not affect `overflow` or `err_count`.
- **clear_stats:** clears `overflow` and `err_count`. If a setting event happens in the same cycle, the event wins:
  - `overflow` ends at 1.
  - `err_count` ends at 1.
- **Reset mid-operation:** all stored entries are abandoned. Memory contents are don't-care.

## Timing
- Reset values:
  - `m_valid`=0, `empty`=1, `full`=0, `count`=0.
  - `overflow`=0, `err_count`=0.
  - `m_data`=0, `m_perr`=0, `m_serr`=0.
- `m_data`, `m_perr` and `m_serr` are registered, which requires a pre-fetch head register. When count==0 they hold their last value.
- Latency:
  - A push at edge N gives `m_valid`=1 and valid `m_data` after edge N, with no extra cycle.
  - A pop at edge N presents the next entry after edge N.
- `m_data`, `m_perr` and `m_serr` are stable while `m_valid` is high and `m_ready` is low.
- `count`, `full`, `empty`, `overflow` and `err_count` update at the same edge as the push or pop that changes them.
- Back-to-back `rx_valid` on consecutive cycles must be accepted. `uart_top` never does this, but the bench does.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8.
  - `RX_ENTRY_W`=10.
  - Field index constants `RX_PERR_BIT`=8 and `RX_SERR_BIT`=9.
- One sub-module `uart_fifo_ram`:
  - Parameterised DEPTH×width register array.
  - One synchronous write port.
  - One asynchronous read port.
- The pointer, count, head-register and status logic stays in `uart_rx_fifo`.

## Test plan
- **Loopback with `uart_top`:** send 0x55, 0xAA, 0x12 with `m_ready`=0, then raise `m_ready`.
  - Output is 0x55, 0xAA, 0x12 in order with perr=serr=0.
  - `count` goes 3→0.
- **Fill DEPTH=16:** push 0x00..0x0F, then push 0x10.
  - `full`=1, `overflow`=1, `count`=16.
  - Draining yields 0x00..0x0F only.
- **Full with same-cycle pop:** FIFO full, push 0x99 in the same cycle as a pop.
  - `count` stays 16, `overflow` stays 0.
  - 0x99 is the last entry out.
- **Error flags:** push 0x3C with parity_error=1, then 0x3D with stop_error=1.
  - `DROP_ERRORS`=0: entries come out with {perr,serr}={1,0} and {0,1}; `err_count`=2.
  - `DROP_ERRORS`=1: FIFO stays empty; `err_count`=2.
- **Saturation and clear:** 300 errored pushes give `err_count`=255. Assert `clear_stats` in the same cycle as an errored push; the next cycle shows `err_count`=1.
- **Flush and reset:**
  - With 5 entries stored, `flush` together with a push gives `count`=0, `empty`=1, `overflow` unchanged.
  - `rst` asserted mid-stream gives all outputs at their reset values on the next cycle.
